// File: rtl/m_stopwatch_counter.sv
// m_stopwatch_counter: BCD stopwatch (cs/sec/min) with start/stop/clear FSM; optional lap hold via STOPWATCH_LAP_EN
module m_stopwatch_counter #(
  parameter int P_MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk10ms,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       running,
  output logic       overflow
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [7:0] MIN_MAX = {4'(P_MIN_MAX / 10), 4'(P_MIN_MAX % 10)};

  // Returns {wrap, next} for a two-digit BCD value that wraps after max.
  function automatic logic [8:0] inc2(input logic [7:0] v, input logic [7:0] max);
    return (v == max) ? 9'h100 :
           (v[3:0] == 4'd9) ? {1'b0, v[7:4] + 4'd1, 4'd0} : {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [1:0] state_q, state_d;
  logic       clk10ms_q;
  logic [7:0] cs_q, cs_d, sec_q, sec_d, min_q, min_d;
  logic       overflow_q, overflow_d;
  logic       tick, cnt, c_cs, c_sec, c_min;
  logic [7:0] cs_inc, sec_inc, min_inc;

  always_comb begin
    tick = clk10ms & ~clk10ms_q;
    cnt = tick & (state_q == S_RUN) & ~clear;
    {c_cs, cs_inc} = inc2(cs_q, 8'h99);
    {c_sec, sec_inc} = inc2(sec_q, 8'h59);
    {c_min, min_inc} = inc2(min_q, MIN_MAX);
    cs_d = clear ? 8'h00 : cnt ? cs_inc : cs_q;
    sec_d = clear ? 8'h00 : (cnt & c_cs) ? sec_inc : sec_q;
    min_d = clear ? 8'h00 : (cnt & c_cs & c_sec) ? min_inc : min_q;
    overflow_d = ~clear & (overflow_q | (cnt & c_cs & c_sec & c_min));
    state_d = clear ? S_IDLE :
              (state_q == S_RUN)   ? (start_stop ? S_PAUSE : S_RUN) :
              (state_q == S_PAUSE) ? (start_stop ? S_RUN : S_PAUSE) :
              (state_q == S_IDLE)  ? (start_stop ? S_RUN : S_IDLE) : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk10ms_q  <= 1'b1;
      cs_q       <= 8'h00;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk10ms_q  <= clk10ms;
      cs_q       <= cs_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = state_q == S_RUN;
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic        hold_q, hold_d;
  logic [23:0] snap_q, snap_d;

  // Snapshot the displayed count when hold engages; the live count keeps running underneath.
  always_comb begin
    hold_d = clear ? 1'b0 :
             (lap & (state_q == S_RUN)) ? ~hold_q :
             (lap & (state_q == S_PAUSE)) ? 1'b0 : hold_q;
    snap_d = (hold_d & ~hold_q) ? {min_q, sec_q, cs_q} : snap_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      snap_q <= 24'h0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign {min_bcd, sec_bcd, cs_bcd} = hold_q ? snap_q : {min_q, sec_q, cs_q};
`else
  assign {min_bcd, sec_bcd, cs_bcd} = {min_q, sec_q, cs_q};
`endif
endmodule

// File: tb/tb_m_stopwatch_counter.sv
// tb_m_stopwatch_counter: two instances (P_MIN_MAX 59 and 1) checked every cycle against a centisecond-integer model
module tb_m_stopwatch_counter;
  localparam int L0 = 60 * 6000;
  localparam int L1 = 2 * 6000;

  logic clk = 0, rst, clk10ms, start_stop, clear;
  logic [7:0] cs0, sec0, min0, cs1, sec1, min1;
  logic run0, ov0, run1, ov1;
  int passes = 0, total = 0;

  int m_n0, m_n1, m_st;
  logic m_prev, m_ov0, m_ov1;

  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  logic lap = 1'b0;
  m_stopwatch_counter #(.P_MIN_MAX(59)) u0 (.clk(clk), .rst(rst), .clk10ms(clk10ms), .start_stop(start_stop),
    .clear(clear), .lap(lap), .cs_bcd(cs0), .sec_bcd(sec0), .min_bcd(min0), .running(run0), .overflow(ov0));
  m_stopwatch_counter #(.P_MIN_MAX(1)) u1 (.clk(clk), .rst(rst), .clk10ms(clk10ms), .start_stop(start_stop),
    .clear(clear), .lap(lap), .cs_bcd(cs1), .sec_bcd(sec1), .min_bcd(min1), .running(run1), .overflow(ov1));
`else
  m_stopwatch_counter #(.P_MIN_MAX(59)) u0 (.clk(clk), .rst(rst), .clk10ms(clk10ms), .start_stop(start_stop),
    .clear(clear), .cs_bcd(cs0), .sec_bcd(sec0), .min_bcd(min0), .running(run0), .overflow(ov0));
  m_stopwatch_counter #(.P_MIN_MAX(1)) u1 (.clk(clk), .rst(rst), .clk10ms(clk10ms), .start_stop(start_stop),
    .clear(clear), .cs_bcd(cs1), .sec_bcd(sec1), .min_bcd(min1), .running(run1), .overflow(ov1));
`endif

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: elapsed centiseconds as one integer, state as 0 idle / 1 run / 2 pause.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev <= 1'b1; m_st <= 0; m_n0 <= 0; m_n1 <= 0; m_ov0 <= 1'b0; m_ov1 <= 1'b0;
    end else begin
      m_prev <= clk10ms;
      m_st <= clear ? 0 : start_stop ? (m_st == 1 ? 2 : 1) : m_st;
      if (clear) begin
        m_n0 <= 0; m_n1 <= 0; m_ov0 <= 1'b0; m_ov1 <= 1'b0;
      end else if (clk10ms && !m_prev && m_st == 1) begin
        m_n0 <= (m_n0 + 1) % L0;
        m_n1 <= (m_n1 + 1) % L1;
        if (m_n0 + 1 == L0) m_ov0 <= 1'b1;
        if (m_n1 + 1 == L1) m_ov1 <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cs0", cs0, bcd(m_n0 % 100));
    chk("sec0", sec0, bcd((m_n0 / 100) % 60));
    chk("min0", min0, bcd(m_n0 / 6000));
    chk("run0", {7'd0, run0}, {7'd0, m_st == 1});
    chk("ov0", {7'd0, ov0}, {7'd0, m_ov0});
    chk("cs1", cs1, bcd(m_n1 % 100));
    chk("sec1", sec1, bcd((m_n1 / 100) % 60));
    chk("min1", min1, bcd(m_n1 / 6000));
    chk("run1", {7'd0, run1}, {7'd0, m_st == 1});
    chk("ov1", {7'd0, ov1}, {7'd0, m_ov1});
  end

  task automatic tick();
    clk10ms = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    clk10ms = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_clr();
    clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clk10ms = 1'b1; start_stop = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_cs_hi", cs0, 8'h00);
    chk("t1_run", {7'd0, run0}, 8'h00);
    clk10ms = 1'b0;
    pulse_clr(); pulse_clr();
    chk("t1_cs", cs0, 8'h00);
    chk("t1_sec", sec0, 8'h00);

    pulse_ss();
    repeat (150) tick();
    chk("t2_cs", cs0, 8'h50);
    chk("t2_sec", sec0, 8'h01);
    chk("t2_min", min0, 8'h00);
    chk("t2_run", {7'd0, run0}, 8'h01);
    chk("t2_model", bcd(m_n0 % 100), 8'h50);

    pulse_clr(); pulse_ss();
    repeat (42) tick();
    chk("t3_cs42", cs0, 8'h42);
    start_stop = 1'b1; clk10ms = 1'b1; @(negedge clk);
    start_stop = 1'b0; clk10ms = 1'b0; @(negedge clk);
    chk("t3_cs43", cs0, 8'h43);
    chk("t3_pause", {7'd0, run0}, 8'h00);
    repeat (5) tick();
    chk("t3_held", cs0, 8'h43);
    pulse_ss();
    chk("t3_rerun", {7'd0, run0}, 8'h01);
    chk("t3_cs", cs0, 8'h43);

    repeat (5956) tick();
    chk("t4_cs99", cs0, 8'h99);
    chk("t4_sec59", sec0, 8'h59);
    clk10ms = 1'b1; @(negedge clk);
    chk("t4_min", min0, 8'h01);
    chk("t4_sec", sec0, 8'h00);
    chk("t4_cs", cs0, 8'h00);
    clk10ms = 1'b0; @(negedge clk);

    repeat (5999) tick();
    chk("t5_min1", min1, 8'h01);
    chk("t5_sec1", sec1, 8'h59);
    chk("t5_cs1", cs1, 8'h99);
    tick();
    chk("t5_wrap_min", min1, 8'h00);
    chk("t5_wrap_cs", cs1, 8'h00);
    chk("t5_ov1", {7'd0, ov1}, 8'h01);
    chk("t5_min0", min0, 8'h02);
    chk("t5_ov0", {7'd0, ov0}, 8'h00);
    chk("t5_model", {7'd0, m_ov1}, 8'h01);
    tick();
    chk("t5_cs01", cs1, 8'h01);
    chk("t5_ov_sticky", {7'd0, ov1}, 8'h01);
    pulse_clr();
    chk("t5_ov_clr", {7'd0, ov1}, 8'h00);
    chk("t5_idle", {7'd0, run1}, 8'h00);

    pulse_ss();
    repeat (1234) tick();
    chk("t6_sec", sec0, 8'h12);
    chk("t6_cs", cs0, 8'h34);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t6_rst_cs", cs0, 8'h00);
    chk("t6_rst_sec", sec0, 8'h00);
    chk("t6_rst_run", {7'd0, run0}, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    repeat (3000) begin
      clk10ms = 1'($urandom_range(0, 1));
      start_stop = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    start_stop = 1'b0; clear = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
